// File: rtl/rv32_fetch_pkg.sv
// rtl/rv32_fetch_pkg.sv - shared types and constants for the RV32 fetch stage
//
// Purpose : fetch FSM state encoding, NOP encoding, default reset vector,
//           skid/IF entry record and a wrapping PC+4 helper.
// Ports   : none (package).
// Config  : PC_MISALIGN_CHECK_EN adds the HALT state.
package rv32_fetch_pkg;

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

`ifdef PC_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_DRAIN = 2'd1
  } fetch_state_e;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } fetch_entry_t;

  // 32-bit add, so 32'hFFFF_FFFC + 4 wraps to 0.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - instruction-cache request bus of the fetch stage
//
// Purpose : groups the fetch-to-icache read handshake.
// Signals : imem_read     - read request (fetch -> cache)
//           imem_addr     - request address, stable while imem_read=1
//           imem_busywait - cache not ready (cache -> fetch)
//           imem_rdata    - instruction word, valid in the completing cycle
// Modports: master (fetch unit), slave (instruction cache).
interface pc_fetch_unit_if;

  logic        imem_read;
  logic [31:0] imem_addr;
  logic        imem_busywait;
  logic [31:0] imem_rdata;

  modport master (
    output imem_read,
    output imem_addr,
    input  imem_busywait,
    input  imem_rdata
  );

  modport slave (
    input  imem_read,
    input  imem_addr,
    output imem_busywait,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry skid register for words returned during a stall
//
// Purpose : holds one {pc, pc4, instr, valid} record while the hazard unit
//           stalls the IF outputs.
// Ports   : clk_i, rst_i  - clock, synchronous active-high reset
//           load_i        - capture entry_i, mark valid
//           unload_i      - entry consumed, mark empty
//           clear_i       - flush (redirect), highest priority after reset
//           entry_i       - record to capture
//           valid_o       - buffer holds a live record
//           entry_o       - buffered record
module fetch_skid_buf
  import rv32_fetch_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         unload_i,
  input  logic         clear_i,
  input  fetch_entry_t entry_i,
  output logic         valid_o,
  output fetch_entry_t entry_o
);

  logic         valid_q;
  fetch_entry_t entry_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      valid_q <= 1'b0;
      entry_q <= '{pc: 32'h0, pc4: 32'h0, instr: NOP_INSTR};
    end else if (load_i) begin
      valid_q <= 1'b1;
      entry_q <= entry_i;
    end else if (unload_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign entry_o = entry_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - RV32IM instruction-fetch stage (PC, icache request, IF outputs)
//
// Purpose : holds the PC, issues icache reads, presents {pc, pc4, instr} to
//           IF/ID, absorbs stalls through a one-entry skid buffer and handles
//           taken-branch redirects, draining any in-flight request first.
// Ports   : clk_i, reset_i   - clock, synchronous active-high reset
//           stall_i          - hold IF outputs, launch no new request
//           branch_taken_i   - one-cycle redirect pulse from EX
//           branch_target_i  - redirect address
//           imem             - icache request bus (master)
//           if_valid_o       - IF outputs carry a live instruction
//           if_pc_o/if_pc4_o - PC and PC+4 of the presented instruction
//           if_instr_o       - instruction word, NOP when not valid
//           misalign_o       - sticky misaligned-target flag (macro only)
// Config  : PC_MISALIGN_CHECK_EN enables misalign_o and the HALT state;
//           without it the low two target bits are ignored.
module pc_fetch_unit
  import rv32_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   stall_i,
  input  logic                   branch_taken_i,
  input  logic [31:0]            branch_target_i,
  pc_fetch_unit_if.master        imem,
  output logic                   if_valid_o,
  output logic [31:0]            if_pc_o,
  output logic [31:0]            if_pc4_o,
  output logic [31:0]            if_instr_o
`ifdef PC_MISALIGN_CHECK_EN
  ,
  output logic                   misalign_o
`endif
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  req_addr_q;
  logic         outstanding_q;
  logic         if_valid_q;
  logic [31:0]  if_pc_q;
  logic [31:0]  if_pc4_q;
  logic [31:0]  if_instr_q;
`ifdef PC_MISALIGN_CHECK_EN
  logic         misalign_q;
  logic         target_bad;
`endif

  logic         launch;
  logic         imem_read;
  logic [31:0]  imem_addr;
  logic         complete;
  logic         inflight;
  logic [31:0]  target;

  logic         skid_valid;
  logic         skid_load;
  logic         skid_unload;
  fetch_entry_t skid_in;
  fetch_entry_t skid_out;

`ifdef PC_MISALIGN_CHECK_EN
  assign target     = branch_target_i;
  assign target_bad = |branch_target_i[1:0];
`else
  assign target     = branch_target_i & ~32'd3;
`endif

  // A new request needs an idle bus, no stall, an empty skid and no
  // redirect this cycle (a launch to the old PC would only have to be drained).
  assign launch = !reset_i && (state_q == ST_REQ) && !outstanding_q &&
                  !stall_i && !skid_valid && !branch_taken_i;

  // Once issued, a request stays up until it completes, whatever the state.
  assign imem_read = !reset_i && (outstanding_q || launch);
  assign imem_addr = outstanding_q ? req_addr_q : pc_q;
  assign complete  = imem_read && !imem.imem_busywait;
  assign inflight  = imem_read && imem.imem_busywait;

  assign imem.imem_read = imem_read;
  assign imem.imem_addr = imem_addr;

  // In REQ the completing request is always for pc_q.
  assign skid_in     = '{pc: pc_q, pc4: pc_plus4(pc_q), instr: imem.imem_rdata};
  assign skid_load   = !branch_taken_i && (state_q == ST_REQ) && complete && stall_i;
  assign skid_unload = !branch_taken_i && !stall_i && skid_valid;

  fetch_skid_buf u_skid (
    .clk_i    (clk_i),
    .rst_i    (reset_i),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (branch_taken_i),
    .entry_i  (skid_in),
    .valid_o  (skid_valid),
    .entry_o  (skid_out)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_VECTOR;
      req_addr_q    <= RESET_VECTOR;
      outstanding_q <= 1'b0;
      if_valid_q    <= 1'b0;
      if_pc_q       <= 32'h0;
      if_pc4_q      <= 32'h0;
      if_instr_q    <= NOP_INSTR;
`ifdef PC_MISALIGN_CHECK_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      outstanding_q <= inflight;
      if (imem_read) begin
        req_addr_q <= imem_addr;
      end

      case (state_q)
`ifdef PC_MISALIGN_CHECK_EN
        ST_HALT: begin
          // Parked until reset; outstanding_q alone drains a pending request.
        end
`endif
        default: begin
          if (branch_taken_i) begin
            if_valid_q <= 1'b0;
            if_instr_q <= NOP_INSTR;
            pc_q       <= target;
            state_q    <= inflight ? ST_DRAIN : ST_REQ;
`ifdef PC_MISALIGN_CHECK_EN
            if (target_bad) begin
              misalign_q <= 1'b1;
              state_q    <= ST_HALT;
            end
`endif
          end else if (state_q == ST_DRAIN) begin
            // Stale word from before the redirect: drop it.
            if (complete) begin
              state_q <= ST_REQ;
            end
          end else if (complete) begin
            pc_q <= pc_plus4(pc_q);
            if (!stall_i) begin
              if_valid_q <= 1'b1;
              if_pc_q    <= pc_q;
              if_pc4_q   <= pc_plus4(pc_q);
              if_instr_q <= imem.imem_rdata;
            end
          end else if (!stall_i) begin
            if (skid_valid) begin
              if_valid_q <= 1'b1;
              if_pc_q    <= skid_out.pc;
              if_pc4_q   <= skid_out.pc4;
              if_instr_q <= skid_out.instr;
            end else begin
              if_valid_q <= 1'b0;
              if_instr_q <= NOP_INSTR;
            end
          end
        end
      endcase
    end
  end

  assign if_valid_o = if_valid_q;
  assign if_pc_o    = if_pc_q;
  assign if_pc4_o   = if_pc4_q;
  assign if_instr_o = if_instr_q;
`ifdef PC_MISALIGN_CHECK_EN
  assign misalign_o = misalign_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;
  import rv32_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] tgt = 32'h0;
  logic        busy = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [31:0] if_instr;
`ifdef PC_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h0BAD_F00D;
  endfunction

  pc_fetch_unit_if bus ();
  assign bus.imem_busywait = busy;
  assign bus.imem_rdata    = busy ? 32'hDEAD_BEEF : mem_word(bus.imem_addr);

  pc_fetch_unit dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .stall_i         (stall),
    .branch_taken_i  (br),
    .branch_target_i (tgt),
    .imem            (bus),
    .if_valid_o      (if_valid),
    .if_pc_o         (if_pc),
    .if_pc4_o        (if_pc4),
    .if_instr_o      (if_instr)
`ifdef PC_MISALIGN_CHECK_EN
    ,
    .misalign_o      (misalign)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: PCs of words that must reach IF, in order.
  logic [31:0] sb_q[$];
  logic        st_s;
  logic        rs_s;

  always @(posedge clk) begin
    st_s = stall;
    rs_s = reset;
    #1;
    // With STALL low a valid IF output is always a freshly presented word.
    if (!rs_s && !st_s && if_valid) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got pc %h expected no instruction", if_pc);
      end else begin
        logic [31:0] e;
        e = sb_q.pop_front();
        check("sb_pc", if_pc, e);
        check("sb_pc4", if_pc4, e + 32'd4);
        check("sb_instr", if_instr, mem_word(e));
      end
    end
  end

  typedef struct {
    logic        stall;
    logic        busy;
    logic        br;
    logic [31:0] tgt;
    logic        exp_read;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        push;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic b, input logic r, input logic [31:0] t,
                              input logic er, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ep, input logic p);
    vec_t v;
    v.stall = s; v.busy = b; v.br = r; v.tgt = t;
    v.exp_read = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep; v.push = p;
    return v;
  endfunction

  task automatic check_if(input string tag, input logic ev, input logic [31:0] ep);
    check({tag, " valid"}, {31'h0, if_valid}, {31'h0, ev});
    if (ev) begin
      check({tag, " pc"}, if_pc, ep);
      check({tag, " pc4"}, if_pc4, ep + 32'd4);
      check({tag, " instr"}, if_instr, mem_word(ep));
    end else begin
      check({tag, " instr"}, if_instr, NOP_INSTR);
    end
  endtask

  initial begin
    //            stall busy br tgt             read addr           valid pc            push
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h0000_0000, 1, 32'h0000_0000, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h0000_0004, 1, 32'h0000_0004, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h0000_0008, 1, 32'h0000_0008, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h0000_000C, 1, 32'h0000_000C, 1));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h0000_0010, 0, 32'h0,         0));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h0000_0010, 0, 32'h0,         0));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h0000_0010, 0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h0000_0010, 1, 32'h0000_0010, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h0000_0014, 1, 32'h0000_0014, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h0000_0018, 1, 32'h0000_0018, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h0000_001C, 1, 32'h0000_001C, 1));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h0000_0020, 0, 32'h0,         0));
    vecs.push_back(mk(1, 1, 0, 32'h0,          1, 32'h0000_0020, 0, 32'h0,         0));
    vecs.push_back(mk(1, 0, 0, 32'h0,          1, 32'h0000_0020, 0, 32'h0,         1));
    vecs.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,         0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 0, 32'h0,          0, 32'h0,         1, 32'h0000_0020, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h0000_0024, 1, 32'h0000_0024, 1));
    vecs.push_back(mk(0, 0, 1, 32'h0000_0040,  0, 32'h0,         0, 32'h0,         0));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h0000_0040, 0, 32'h0,         0));
    vecs.push_back(mk(0, 1, 1, 32'h0000_0100,  1, 32'h0000_0040, 0, 32'h0,         0));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h0000_0040, 0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h0000_0040, 0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h0000_0100, 1, 32'h0000_0100, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h0000_0104, 1, 32'h0000_0104, 1));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h0000_0108, 0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 1, 32'h0000_0200,  1, 32'h0000_0108, 0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h0000_0200, 1, 32'h0000_0200, 1));
    vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFF8,  0, 32'h0,         0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'hFFFF_FFF8, 1, 32'hFFFF_FFF8, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h0000_0000, 1, 32'h0000_0000, 1));

    // Reset held for two cycles.
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      check("reset read", {31'h0, bus.imem_read}, 32'h0);
      @(posedge clk);
      #1;
      check("reset valid", {31'h0, if_valid}, 32'h0);
      check("reset pc", if_pc, 32'h0);
      check("reset pc4", if_pc4, 32'h0);
      check("reset instr", if_instr, NOP_INSTR);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = 1'b0;
      stall = vecs[i].stall;
      busy  = vecs[i].busy;
      br    = vecs[i].br;
      tgt   = vecs[i].tgt;
      #1;
      check($sformatf("row%0d read", i), {31'h0, bus.imem_read}, {31'h0, vecs[i].exp_read});
      if (vecs[i].exp_read) begin
        check($sformatf("row%0d addr", i), bus.imem_addr, vecs[i].exp_addr);
      end
      if (vecs[i].push) begin
        sb_q.push_back(vecs[i].exp_addr);
      end
      @(posedge clk);
      #1;
      check_if($sformatf("row%0d", i), vecs[i].exp_valid, vecs[i].exp_pc);
    end

    // Reset while a fetch to 0x4 is waiting on the cache.
    @(negedge clk);
    stall = 1'b0; br = 1'b0; busy = 1'b1;
    #1;
    check("midrst busy read", {31'h0, bus.imem_read}, 32'h1);
    check("midrst busy addr", bus.imem_addr, 32'h4);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst read", {31'h0, bus.imem_read}, 32'h0);
    @(posedge clk);
    #1;
    check_if("midrst", 1'b0, 32'h0);
    check("midrst pc", if_pc, 32'h0);
    @(negedge clk);
    reset = 1'b0; busy = 1'b0;
    #1;
    check("postrst read", {31'h0, bus.imem_read}, 32'h1);
    check("postrst addr", bus.imem_addr, DEFAULT_RESET_VECTOR);
    sb_q.push_back(DEFAULT_RESET_VECTOR);
    @(posedge clk);
    #1;
    check_if("postrst", 1'b1, DEFAULT_RESET_VECTOR);

`ifdef PC_MISALIGN_CHECK_EN
    @(negedge clk);
    br = 1'b1; tgt = 32'h0000_0102;
    @(posedge clk);
    #1;
    check("mis flag", {31'h0, misalign}, 32'h1);
    check_if("mis", 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      br = 1'b0;
      #1;
      check($sformatf("mis halt read%0d", k), {31'h0, bus.imem_read}, 32'h0);
      @(posedge clk);
      #1;
      check($sformatf("mis sticky%0d", k), {31'h0, misalign}, 32'h1);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mis cleared", {31'h0, misalign}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    sb_q.push_back(DEFAULT_RESET_VECTOR);
    #1;
    check("mis refetch read", {31'h0, bus.imem_read}, 32'h1);
    @(posedge clk);
    #1;
    check_if("mis refetch", 1'b1, DEFAULT_RESET_VECTOR);
`else
    @(negedge clk);
    br = 1'b1; tgt = 32'h0000_0302;
    #1;
    check("align br read", {31'h0, bus.imem_read}, 32'h0);
    @(posedge clk);
    #1;
    check_if("align br", 1'b0, 32'h0);
    @(negedge clk);
    br = 1'b0;
    #1;
    check("align addr", bus.imem_addr, 32'h0000_0300);
    sb_q.push_back(32'h0000_0300);
    @(posedge clk);
    #1;
    check_if("align", 1'b1, 32'h0000_0300);
`endif

    @(negedge clk);
    stall = 1'b1;
    @(posedge clk);
    #2;
    check("sb drained", sb_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
